// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the data memory between the core and a host port with a starvation guard; optional stats under DM_ARB_STATS_EN
module dm_arbiter #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [7:0]        stat_host_cnt,
  output logic [7:0]        stat_stall_cnt
);
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve;
  owner_t     owner;
  logic       force_host;
  assign force_host = starve == LIMIT;
  // core wins by default; a starved host takes one slot; memory parks on the core address when idle
  always_comb begin
    cpu_gnt   = reset && cpu_req && !(host_req && force_host);
    host_gnt  = reset && host_req && (!cpu_req || force_host);
    mem_addr  = host_gnt ? host_addr : cpu_addr;
    mem_wdata = host_gnt ? host_wdata : cpu_wdata;
    mem_we    = host_gnt ? host_we : cpu_gnt && cpu_we;
    cpu_rdata = owner == OWN_CPU ? mem_rdata : '0;
  end
  // starvation counter, last owner and registered host read return
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve      <= '0;
      owner       <= OWN_CPU;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      starve      <= (host_gnt || !host_req) ? 4'd0 : force_host ? starve : starve + 4'd1;
      owner       <= cpu_gnt ? OWN_CPU : host_gnt ? OWN_HOST : OWN_NONE;
      host_rvalid <= host_gnt && !host_we;
      if (host_gnt && !host_we) host_rdata <= mem_rdata;
    end
  end
`ifdef DM_ARB_STATS_EN
  logic [7:0] host_cnt, stall_cnt;
  // saturating host-grant and core-stall counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      host_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (host_gnt && host_cnt != 8'hff) host_cnt <= host_cnt + 8'd1;
      if (cpu_req && !cpu_gnt && stall_cnt != 8'hff) stall_cnt <= stall_cnt + 8'd1;
    end
  end
  assign stat_host_cnt  = host_cnt;
  assign stat_stall_cnt = stall_cnt;
`else
  assign stat_host_cnt  = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of dm_arbiter against a negedge-clocked memory model
module tb_dm_arbiter;
  logic       clk = 0, reset = 0;
  logic       cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
  logic [3:0] cpu_addr = 0, cpu_wdata = 0, host_addr = 0, host_wdata = 0;
  logic       cpu_gnt, host_gnt, host_rvalid, mem_we;
  logic [3:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] stat_host_cnt, stat_stall_cnt;
  logic [3:0] mem [16] = '{default: 4'h0};
  int n_cmp = 0, n_err = 0;
  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    cyc();
    cpu_req = 1; cpu_we = 1; host_req = 1; host_we = 1;
    #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_host_gnt", host_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_stat_host", stat_host_cnt, 0);
    chk("rst_stat_stall", stat_stall_cnt, 0);
    cpu_req = 0; cpu_we = 0; host_req = 0; host_we = 0;
    cyc();
    reset = 1;
    #1;
    chk("idle_cpu_gnt", cpu_gnt, 0);
    chk("idle_host_gnt", host_gnt, 0);
    cyc();
    cpu_req = 1; cpu_we = 1; cpu_addr = 3; cpu_wdata = 4'hA;
    #1;
    chk("cw_gnt", cpu_gnt, 1);
    chk("cw_mem_we", mem_we, 1);
    chk("cw_mem_addr", mem_addr, 3);
    cyc();
    cpu_we = 0;
    #1;
    chk("cr_gnt", cpu_gnt, 1);
    chk("cr_mem_we", mem_we, 0);
    cyc();
    cpu_req = 0;
    #1;
    chk("cr_rdata", cpu_rdata, 4'hA);
    host_req = 1; host_we = 1; host_addr = 4'hF; host_wdata = 4'h5;
    #1;
    chk("hw_gnt", host_gnt, 1);
    chk("hw_mem_we", mem_we, 1);
    chk("hw_mem_addr", mem_addr, 4'hF);
    cyc();
    chk("hw_no_rvalid", host_rvalid, 0);
    host_we = 0;
    #1;
    chk("hr_gnt", host_gnt, 1);
    chk("hr_mem_we", mem_we, 0);
    cyc();
    host_req = 0;
    #1;
    chk("hr_rvalid", host_rvalid, 1);
    chk("hr_rdata", host_rdata, 4'h5);
    chk("hr_cpu_rdata_zero", cpu_rdata, 0);
    cyc();
    chk("hr_rvalid_drop", host_rvalid, 0);
    host_req = 1; host_addr = 3;
    cyc();
    host_addr = 4'hF;
    chk("b2b_rvalid0", host_rvalid, 1);
    chk("b2b_rdata0", host_rdata, 4'hA);
    cyc();
    host_req = 0;
    chk("b2b_rvalid1", host_rvalid, 1);
    chk("b2b_rdata1", host_rdata, 4'h5);
    cyc();
    cpu_req = 1; cpu_addr = 0; host_req = 1; host_addr = 1;
    for (int i = 1; i <= 18; i++) begin
      #1;
      chk($sformatf("cont_host_%0d", i), host_gnt, (i % 9) == 0);
      chk($sformatf("cont_cpu_%0d", i), cpu_gnt, (i % 9) != 0);
      cyc();
    end
    host_req = 1; host_we = 1; host_addr = 7; host_wdata = 4'hC;
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("wd_gnt_%0d", i), host_gnt, 0);
      chk($sformatf("wd_mem_we_%0d", i), mem_we, 0);
      cyc();
    end
    host_req = 0;
    cyc();
    host_req = 1; host_we = 0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk($sformatf("rq_gnt_%0d", i), host_gnt, i == 9);
      cyc();
    end
    host_req = 0;
    chk("rq_rvalid", host_rvalid, 1);
    chk("rq_rdata_unwritten", host_rdata, 0);
    host_req = 1; host_addr = 4'hF;
    for (int i = 0; i < 4; i++) cyc();
    cpu_req = 0; cpu_we = 1;
    reset = 0;
    #1;
    chk("rr_host_gnt", host_gnt, 0);
    chk("rr_cpu_gnt", cpu_gnt, 0);
    chk("rr_mem_we", mem_we, 0);
    cyc();
    reset = 1; cpu_req = 1; cpu_we = 0;
    chk("rr_no_rvalid", host_rvalid, 0);
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk($sformatf("rr_gnt_%0d", i), host_gnt, i == 9);
      cyc();
    end
    reset = 0;
    cyc();
    reset = 1;
    for (int i = 0; i < 300; i++) cyc();
    cpu_req = 0; host_req = 0;
`ifdef DM_ARB_STATS_EN
    chk("stat_host", stat_host_cnt, 33);
    chk("stat_stall", stat_stall_cnt, 33);
`else
    chk("stat_host", stat_host_cnt, 0);
    chk("stat_stall", stat_stall_cnt, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
